// File: rtl/active_list_commit_pkg.sv
// active_list_commit_pkg: shared widths and the active-list entry layout used by rename and retirement
package active_list_commit_pkg;
    localparam int REG_ADDR_WIDTH  = 5;
    localparam int FREE_LIST_WIDTH = 3;
    localparam int DEPTH           = 2 ** FREE_LIST_WIDTH;
    localparam int PHYS_ADDR_WIDTH = REG_ADDR_WIDTH + 1;

    typedef struct packed {
        logic                       valid;
        logic                       done;
        logic                       writes_back;
        logic [REG_ADDR_WIDTH-1:0]  vaddr;
        logic [PHYS_ADDR_WIDTH-1:0] new_paddr;
        logic [PHYS_ADDR_WIDTH-1:0] old_paddr;
        logic                       is_branch;
    } al_entry_t;
endpackage

// File: rtl/active_list_commit_ptr.sv
// active_list_ptr: head/tail pointers and occupancy count; full and empty come from the count alone
module active_list_ptr
    import active_list_commit_pkg::*;
(
    input  logic                       i_Clk,
    input  logic                       i_Reset_n,
    input  logic                       i_Flush,
    input  logic                       i_Alloc,
    input  logic                       i_Commit,
    output logic [FREE_LIST_WIDTH-1:0] o_Head,
    output logic [FREE_LIST_WIDTH-1:0] o_Tail,
    output logic                       o_Full,
    output logic                       o_Empty
);
    localparam logic [FREE_LIST_WIDTH:0] FULL_COUNT = (FREE_LIST_WIDTH + 1)'(DEPTH);

    logic [FREE_LIST_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [FREE_LIST_WIDTH:0]   count_q, count_d;

    // pointers wrap naturally at DEPTH; flush returns everything to the empty state
    always_comb begin
        head_d  = i_Flush ? '0 : head_q + FREE_LIST_WIDTH'(i_Commit);
        tail_d  = i_Flush ? '0 : tail_q + FREE_LIST_WIDTH'(i_Alloc);
        count_d = i_Flush ? '0 : count_q + (FREE_LIST_WIDTH + 1)'(i_Alloc) - (FREE_LIST_WIDTH + 1)'(i_Commit);
    end

    // pointer and count registers
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign o_Head  = head_q;
    assign o_Tail  = tail_q;
    assign o_Full  = count_q == FULL_COUNT;
    assign o_Empty = count_q == '0;
endmodule

// File: rtl/active_list_commit.sv
// active_list_commit: in-order retirement buffer; marks entries done from writeback and retires the head
module active_list_commit
    import active_list_commit_pkg::*;
(
    input  logic                       i_Clk,
    input  logic                       i_Reset_n,
    input  logic                       i_Flush,
    input  logic                       i_Alloc_Valid,
    input  logic                       i_Alloc_Writes_Back,
    input  logic [REG_ADDR_WIDTH-1:0]  i_Alloc_VAddr,
    input  logic [PHYS_ADDR_WIDTH-1:0] i_Alloc_New_PAddr,
    input  logic [PHYS_ADDR_WIDTH-1:0] i_Alloc_Old_PAddr,
    input  logic                       i_Alloc_Is_Branch,
    output logic [FREE_LIST_WIDTH-1:0] o_Alloc_Index,
    output logic                       o_Full,
    output logic                       o_Empty,
    input  logic                       i_Complete_Valid,
    input  logic [FREE_LIST_WIDTH-1:0] i_Complete_Index,
    input  logic                       i_Commit_Stall,
    output logic                       o_Commit_Valid,
    output logic                       o_Commit_Writes_Back,
    output logic [REG_ADDR_WIDTH-1:0]  o_Commit_VAddr,
    output logic [PHYS_ADDR_WIDTH-1:0] o_Commit_PAddr,
    output logic                       o_Free_Valid,
    output logic [PHYS_ADDR_WIDTH-1:0] o_Free_PAddr,
    output logic                       o_Commit_Is_Branch
);
    logic [FREE_LIST_WIDTH-1:0] head, tail;
    logic                       full, empty, alloc_fire, commit_fire;
    al_entry_t                  entries_q [DEPTH];
    al_entry_t                  entries_d [DEPTH];
    al_entry_t                  head_e;
    logic                       cv_q, cv_d, cwb_q, cwb_d, cbr_q, cbr_d;
    logic [REG_ADDR_WIDTH-1:0]  cva_q, cva_d;
    logic [PHYS_ADDR_WIDTH-1:0] cpa_q, cpa_d, fpa_q, fpa_d;

    active_list_ptr u_ptr (
        .i_Clk     (i_Clk),
        .i_Reset_n (i_Reset_n),
        .i_Flush   (i_Flush),
        .i_Alloc   (alloc_fire),
        .i_Commit  (commit_fire),
        .o_Head    (head),
        .o_Tail    (tail),
        .o_Full    (full),
        .o_Empty   (empty)
    );

    // entry updates: complete, then retire the head, then write the new tail entry; flush clears all
    always_comb begin
        head_e      = entries_q[head];
        alloc_fire  = i_Alloc_Valid & ~full;
        commit_fire = ~i_Commit_Stall & ~empty & head_e.valid & head_e.done;
        entries_d   = entries_q;
        if (i_Complete_Valid && entries_q[i_Complete_Index].valid)
            entries_d[i_Complete_Index].done = 1'b1;
        if (commit_fire) begin
            entries_d[head].valid = 1'b0;
            entries_d[head].done  = 1'b0;
        end
        if (alloc_fire)
            entries_d[tail] = '{valid: 1'b1, done: 1'b0, writes_back: i_Alloc_Writes_Back,
                                vaddr: i_Alloc_VAddr, new_paddr: i_Alloc_New_PAddr,
                                old_paddr: i_Alloc_Old_PAddr, is_branch: i_Alloc_Is_Branch};
        cv_d  = commit_fire;
        cwb_d = commit_fire ? head_e.writes_back : cwb_q;
        cva_d = commit_fire ? head_e.vaddr       : cva_q;
        cpa_d = commit_fire ? head_e.new_paddr   : cpa_q;
        fpa_d = commit_fire ? head_e.old_paddr   : fpa_q;
        cbr_d = commit_fire ? head_e.is_branch   : cbr_q;
        if (i_Flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
                entries_d[i].done  = 1'b0;
            end
            cv_d  = 1'b0;
            cwb_d = 1'b0;
            cva_d = '0;
            cpa_d = '0;
            fpa_d = '0;
            cbr_d = 1'b0;
        end
    end

    // entry storage and registered commit outputs
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            entries_q <= '{default: '0};
            cv_q      <= 1'b0;
            cwb_q     <= 1'b0;
            cva_q     <= '0;
            cpa_q     <= '0;
            fpa_q     <= '0;
            cbr_q     <= 1'b0;
        end else begin
            entries_q <= entries_d;
            cv_q      <= cv_d;
            cwb_q     <= cwb_d;
            cva_q     <= cva_d;
            cpa_q     <= cpa_d;
            fpa_q     <= fpa_d;
            cbr_q     <= cbr_d;
        end
    end

    assign o_Alloc_Index        = tail;
    assign o_Full               = full;
    assign o_Empty              = empty;
    assign o_Commit_Valid       = cv_q;
    assign o_Commit_Writes_Back = cwb_q;
    assign o_Commit_VAddr       = cva_q;
    assign o_Commit_PAddr       = cpa_q;
    assign o_Free_Valid         = cv_q & cwb_q;
    assign o_Free_PAddr         = fpa_q;
    assign o_Commit_Is_Branch   = cbr_q;
endmodule

// File: tb/tb_active_list_commit.sv
// tb_active_list_commit: directed scenarios for the active list with hand-computed expectations
module tb_active_list_commit;
    import active_list_commit_pkg::*;

    logic                       i_Clk = 1'b0;
    logic                       i_Reset_n;
    logic                       i_Flush;
    logic                       i_Alloc_Valid;
    logic                       i_Alloc_Writes_Back;
    logic [REG_ADDR_WIDTH-1:0]  i_Alloc_VAddr;
    logic [PHYS_ADDR_WIDTH-1:0] i_Alloc_New_PAddr;
    logic [PHYS_ADDR_WIDTH-1:0] i_Alloc_Old_PAddr;
    logic                       i_Alloc_Is_Branch;
    logic [FREE_LIST_WIDTH-1:0] o_Alloc_Index;
    logic                       o_Full, o_Empty;
    logic                       i_Complete_Valid;
    logic [FREE_LIST_WIDTH-1:0] i_Complete_Index;
    logic                       i_Commit_Stall;
    logic                       o_Commit_Valid, o_Commit_Writes_Back;
    logic [REG_ADDR_WIDTH-1:0]  o_Commit_VAddr;
    logic [PHYS_ADDR_WIDTH-1:0] o_Commit_PAddr;
    logic                       o_Free_Valid;
    logic [PHYS_ADDR_WIDTH-1:0] o_Free_PAddr;
    logic                       o_Commit_Is_Branch;

    int n_vec = 0;
    int n_err = 0;

    active_list_commit dut (
        .i_Clk                (i_Clk),
        .i_Reset_n            (i_Reset_n),
        .i_Flush              (i_Flush),
        .i_Alloc_Valid        (i_Alloc_Valid),
        .i_Alloc_Writes_Back  (i_Alloc_Writes_Back),
        .i_Alloc_VAddr        (i_Alloc_VAddr),
        .i_Alloc_New_PAddr    (i_Alloc_New_PAddr),
        .i_Alloc_Old_PAddr    (i_Alloc_Old_PAddr),
        .i_Alloc_Is_Branch    (i_Alloc_Is_Branch),
        .o_Alloc_Index        (o_Alloc_Index),
        .o_Full               (o_Full),
        .o_Empty              (o_Empty),
        .i_Complete_Valid     (i_Complete_Valid),
        .i_Complete_Index     (i_Complete_Index),
        .i_Commit_Stall       (i_Commit_Stall),
        .o_Commit_Valid       (o_Commit_Valid),
        .o_Commit_Writes_Back (o_Commit_Writes_Back),
        .o_Commit_VAddr       (o_Commit_VAddr),
        .o_Commit_PAddr       (o_Commit_PAddr),
        .o_Free_Valid         (o_Free_Valid),
        .o_Free_PAddr         (o_Free_PAddr),
        .o_Commit_Is_Branch   (o_Commit_Is_Branch)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic cyc();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic idle();
        i_Flush             = 1'b0;
        i_Alloc_Valid       = 1'b0;
        i_Alloc_Writes_Back = 1'b0;
        i_Alloc_VAddr       = '0;
        i_Alloc_New_PAddr   = '0;
        i_Alloc_Old_PAddr   = '0;
        i_Alloc_Is_Branch   = 1'b0;
        i_Complete_Valid    = 1'b0;
        i_Complete_Index    = '0;
        i_Commit_Stall      = 1'b0;
    endtask

    task automatic alloc(input logic wb, input logic [4:0] v, input logic [5:0] np,
                         input logic [5:0] op, input logic br);
        i_Alloc_Valid       = 1'b1;
        i_Alloc_Writes_Back = wb;
        i_Alloc_VAddr       = v;
        i_Alloc_New_PAddr   = np;
        i_Alloc_Old_PAddr   = op;
        i_Alloc_Is_Branch   = br;
    endtask

    task automatic complete(input logic [2:0] idx);
        i_Complete_Valid = 1'b1;
        i_Complete_Index = idx;
    endtask

    task automatic do_reset();
        idle();
        i_Reset_n = 1'b0;
        #2;
        i_Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        i_Reset_n = 1'b0;
        #1;
        n_vec++; if (o_Empty !== 1'b1) begin $display("FAIL rst_empty got %0b exp 1", o_Empty); n_err++; end
        n_vec++; if (o_Full !== 1'b0) begin $display("FAIL rst_full got %0b exp 0", o_Full); n_err++; end
        n_vec++; if (o_Commit_Valid !== 1'b0) begin $display("FAIL rst_cv got %0b exp 0", o_Commit_Valid); n_err++; end
        cyc();
        i_Reset_n = 1'b1;
        alloc(1'b1, 5'd1, 6'd40, 6'd1, 1'b0);
        cyc();
        alloc(1'b1, 5'd2, 6'd41, 6'd2, 1'b0);
        complete(3'd0);
        cyc();
        alloc(1'b1, 5'd5, 6'd42, 6'd5, 1'b0);
        i_Complete_Valid = 1'b0;
        cyc();
        idle();
        n_vec++; if (o_Commit_Valid !== 1'b1) begin $display("FAIL mid_cv got %0b exp 1", o_Commit_Valid); n_err++; end
        n_vec++; if (o_Alloc_Index !== 3'd3) begin $display("FAIL mid_idx got %0d exp 3", o_Alloc_Index); n_err++; end
        #2;
        i_Reset_n = 1'b0;
        #1;
        n_vec++; if (o_Commit_Valid !== 1'b0) begin $display("FAIL async_cv got %0b exp 0", o_Commit_Valid); n_err++; end
        n_vec++; if (o_Empty !== 1'b1) begin $display("FAIL async_empty got %0b exp 1", o_Empty); n_err++; end
        n_vec++; if (o_Alloc_Index !== 3'd0) begin $display("FAIL async_idx got %0d exp 0", o_Alloc_Index); n_err++; end
        #1;
        i_Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_vec++; if (o_Commit_Valid !== 1'b0) begin $display("FAIL post_rst_cv[%0d] got %0b exp 0", i, o_Commit_Valid); n_err++; end
        end
    endtask

    task automatic test_in_order();
        do_reset();
        alloc(1'b1, 5'd3, 6'd33, 6'd3, 1'b0);
        n_vec++; if (o_Alloc_Index !== 3'd0) begin $display("FAIL io_idx0 got %0d exp 0", o_Alloc_Index); n_err++; end
        cyc();
        alloc(1'b1, 5'd4, 6'd34, 6'd4, 1'b0);
        n_vec++; if (o_Alloc_Index !== 3'd1) begin $display("FAIL io_idx1 got %0d exp 1", o_Alloc_Index); n_err++; end
        cyc();
        idle();
        complete(3'd1);
        cyc();
        n_vec++; if (o_Commit_Valid !== 1'b0) begin $display("FAIL io_nocommit1 got %0b exp 0", o_Commit_Valid); n_err++; end
        complete(3'd0);
        cyc();
        idle();
        n_vec++; if (o_Commit_Valid !== 1'b0) begin $display("FAIL io_nocommit0 got %0b exp 0", o_Commit_Valid); n_err++; end
        cyc();
        n_vec++; if (o_Commit_Valid !== 1'b1) begin $display("FAIL io_c0_valid got %0b exp 1", o_Commit_Valid); n_err++; end
        n_vec++; if (o_Commit_VAddr !== 5'd3) begin $display("FAIL io_c0_vaddr got %0d exp 3", o_Commit_VAddr); n_err++; end
        n_vec++; if (o_Commit_PAddr !== 6'd33) begin $display("FAIL io_c0_paddr got %0d exp 33", o_Commit_PAddr); n_err++; end
        n_vec++; if (o_Free_Valid !== 1'b1) begin $display("FAIL io_c0_fv got %0b exp 1", o_Free_Valid); n_err++; end
        n_vec++; if (o_Free_PAddr !== 6'd3) begin $display("FAIL io_c0_free got %0d exp 3", o_Free_PAddr); n_err++; end
        cyc();
        n_vec++; if (o_Commit_Valid !== 1'b1) begin $display("FAIL io_c1_valid got %0b exp 1", o_Commit_Valid); n_err++; end
        n_vec++; if (o_Commit_VAddr !== 5'd4) begin $display("FAIL io_c1_vaddr got %0d exp 4", o_Commit_VAddr); n_err++; end
        n_vec++; if (o_Commit_PAddr !== 6'd34) begin $display("FAIL io_c1_paddr got %0d exp 34", o_Commit_PAddr); n_err++; end
        n_vec++; if (o_Free_PAddr !== 6'd4) begin $display("FAIL io_c1_free got %0d exp 4", o_Free_PAddr); n_err++; end
        cyc();
        n_vec++; if (o_Commit_Valid !== 1'b0) begin $display("FAIL io_after_cv got %0b exp 0", o_Commit_Valid); n_err++; end
        n_vec++; if (o_Commit_VAddr !== 5'd4) begin $display("FAIL io_hold_vaddr got %0d exp 4", o_Commit_VAddr); n_err++; end
        n_vec++; if (o_Empty !== 1'b1) begin $display("FAIL io_empty got %0b exp 1", o_Empty); n_err++; end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            alloc(1'b1, 5'(i), 6'(32 + i), 6'(i), 1'b0);
            cyc();
        end
        idle();
        n_vec++; if (o_Full !== 1'b1) begin $display("FAIL fw_full got %0b exp 1", o_Full); n_err++; end
        n_vec++; if (o_Empty !== 1'b0) begin $display("FAIL fw_empty got %0b exp 0", o_Empty); n_err++; end
        n_vec++; if (o_Alloc_Index !== 3'd0) begin $display("FAIL fw_idx got %0d exp 0", o_Alloc_Index); n_err++; end
        alloc(1'b1, 5'd31, 6'd63, 6'd31, 1'b0);
        cyc();
        idle();
        n_vec++; if (o_Alloc_Index !== 3'd0) begin $display("FAIL fw_drop_idx got %0d exp 0", o_Alloc_Index); n_err++; end
        n_vec++; if (o_Full !== 1'b1) begin $display("FAIL fw_drop_full got %0b exp 1", o_Full); n_err++; end
        complete(3'd0);
        cyc();
        idle();
        cyc();
        n_vec++; if (o_Commit_Valid !== 1'b1) begin $display("FAIL fw_cv got %0b exp 1", o_Commit_Valid); n_err++; end
        n_vec++; if (o_Commit_PAddr !== 6'd32) begin $display("FAIL fw_paddr got %0d exp 32", o_Commit_PAddr); n_err++; end
        n_vec++; if (o_Full !== 1'b0) begin $display("FAIL fw_notfull got %0b exp 0", o_Full); n_err++; end
        alloc(1'b1, 5'd9, 6'd41, 6'd9, 1'b0);
        cyc();
        idle();
        n_vec++; if (o_Full !== 1'b1) begin $display("FAIL fw_refull got %0b exp 1", o_Full); n_err++; end
        n_vec++; if (o_Alloc_Index !== 3'd1) begin $display("FAIL fw_wrap_idx got %0d exp 1", o_Alloc_Index); n_err++; end
        complete(3'd1);
        cyc();
        idle();
        cyc();
        n_vec++; if (o_Commit_VAddr !== 5'd1) begin $display("FAIL fw_next_head got %0d exp 1", o_Commit_VAddr); n_err++; end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc(1'b1, 5'(10 + i), 6'(20 + i), 6'(i), 1'b0);
            if (i == 3) complete(3'd0);
            cyc();
        end
        idle();
        alloc(1'b1, 5'd14, 6'd24, 6'd4, 1'b0);
        complete(3'd1);
        cyc();
        idle();
        n_vec++; if (o_Commit_Valid !== 1'b1) begin $display("FAIL sim_cv got %0b exp 1", o_Commit_Valid); n_err++; end
        n_vec++; if (o_Commit_VAddr !== 5'd10) begin $display("FAIL sim_vaddr got %0d exp 10", o_Commit_VAddr); n_err++; end
        n_vec++; if (o_Alloc_Index !== 3'd5) begin $display("FAIL sim_tail got %0d exp 5", o_Alloc_Index); n_err++; end
        i_Commit_Stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alloc(1'b1, 5'(15 + i), 6'(25 + i), 6'(5 + i), 1'b0);
            cyc();
            if (i == 2) begin
                n_vec++; if (o_Full !== 1'b0) begin $display("FAIL sim_count7_full got %0b exp 0", o_Full); n_err++; end
            end
        end
        i_Alloc_Valid = 1'b0;
        n_vec++; if (o_Full !== 1'b1) begin $display("FAIL sim_count8_full got %0b exp 1", o_Full); n_err++; end
        n_vec++; if (o_Alloc_Index !== 3'd1) begin $display("FAIL sim_wrap_tail got %0d exp 1", o_Alloc_Index); n_err++; end
        n_vec++; if (o_Commit_Valid !== 1'b0) begin $display("FAIL sim_stalled_cv got %0b exp 0", o_Commit_Valid); n_err++; end
        i_Commit_Stall = 1'b0;
        cyc();
        n_vec++; if (o_Commit_VAddr !== 5'd11) begin $display("FAIL sim_head_adv got %0d exp 11", o_Commit_VAddr); n_err++; end
        n_vec++; if (o_Commit_Valid !== 1'b1) begin $display("FAIL sim_head_cv got %0b exp 1", o_Commit_Valid); n_err++; end
    endtask

    task automatic test_flush();
        do_reset();
        alloc(1'b1, 5'd6, 6'd38, 6'd6, 1'b0);
        cyc();
        idle();
        complete(3'd0);
        cyc();
        alloc(1'b1, 5'd7, 6'd39, 6'd7, 1'b0);
        i_Flush = 1'b1;
        cyc();
        idle();
        n_vec++; if (o_Commit_Valid !== 1'b0) begin $display("FAIL fl_cv got %0b exp 0", o_Commit_Valid); n_err++; end
        n_vec++; if (o_Empty !== 1'b1) begin $display("FAIL fl_empty got %0b exp 1", o_Empty); n_err++; end
        n_vec++; if (o_Alloc_Index !== 3'd0) begin $display("FAIL fl_tail got %0d exp 0", o_Alloc_Index); n_err++; end
        cyc();
        n_vec++; if (o_Commit_Valid !== 1'b0) begin $display("FAIL fl_after_cv got %0b exp 0", o_Commit_Valid); n_err++; end
    endtask

    task automatic test_no_dest();
        do_reset();
        alloc(1'b0, 5'd7, 6'd39, 6'd7, 1'b1);
        cyc();
        idle();
        i_Commit_Stall = 1'b1;
        complete(3'd0);
        cyc();
        i_Complete_Valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_vec++; if (o_Commit_Valid !== 1'b0) begin $display("FAIL nd_stall_cv[%0d] got %0b exp 0", i, o_Commit_Valid); n_err++; end
        end
        i_Commit_Stall = 1'b0;
        cyc();
        n_vec++; if (o_Commit_Valid !== 1'b1) begin $display("FAIL nd_cv got %0b exp 1", o_Commit_Valid); n_err++; end
        n_vec++; if (o_Commit_Is_Branch !== 1'b1) begin $display("FAIL nd_br got %0b exp 1", o_Commit_Is_Branch); n_err++; end
        n_vec++; if (o_Commit_Writes_Back !== 1'b0) begin $display("FAIL nd_wb got %0b exp 0", o_Commit_Writes_Back); n_err++; end
        n_vec++; if (o_Free_Valid !== 1'b0) begin $display("FAIL nd_fv got %0b exp 0", o_Free_Valid); n_err++; end
        n_vec++; if (o_Commit_VAddr !== 5'd7) begin $display("FAIL nd_vaddr got %0d exp 7", o_Commit_VAddr); n_err++; end
        cyc();
        n_vec++; if (o_Commit_Valid !== 1'b0) begin $display("FAIL nd_pulse got %0b exp 0", o_Commit_Valid); n_err++; end
        n_vec++; if (o_Commit_Is_Branch !== 1'b1) begin $display("FAIL nd_hold_br got %0b exp 1", o_Commit_Is_Branch); n_err++; end
        n_vec++; if (o_Empty !== 1'b1) begin $display("FAIL nd_empty got %0b exp 1", o_Empty); n_err++; end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full_wrap();
        test_simultaneous();
        test_flush();
        test_no_dest();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
